dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit: the initiator side of the parallel data-memory interface, driven by the core's execute stage.
- Accepts one RV32I load/store per handshake and converts byte/half/word accesses into word accesses on a memory that has only word-wide read/write and a single write enable.
- Sub-word stores use read-modify-write.
- Returns sign/zero-extended load data, or an error for misaligned or illegal requests.

Parameters:
- ADDR_WIDTH, 11, number of word-index bits driven to memory (2K words); byte-address bits above ADDR_WIDTH+1 are ignored (wrap).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  LSU idle, can accept a request
- i_req_write  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I width/sign code
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- o_resp_valid  out  1  one-cycle completion pulse; no backpressure
- o_resp_rdata  out  32  extended load data; 0 for stores and errors
- o_resp_error  out  1  misaligned or illegal funct3, qualified by o_resp_valid
- o_mem_addr  out  32  word index {zeros, addr[ADDR_WIDTH+1:2]}
- o_mem_write_data  out  32  word written to memory
- o_mem_write_enable  out  1  1 = write this cycle, 0 = read
- i_mem_read_data  in  32  read word; valid the cycle after o_mem_addr is presented with o_mem_write_enable=0

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: state IDLE; o_req_ready=1; o_resp_valid=0; o_resp_error=0; o_resp_rdata=0; o_mem_addr=0; o_mem_write_data=0; o_mem_write_enable=0.
- Accept: a request is taken on a clock edge where i_req_valid && o_req_ready. At that edge, latch addr, funct3, write and wdata. o_req_ready=1 only in IDLE.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Legal stores: SB 000, SH 001, SW 010.
- Any other code is illegal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- States: IDLE, ACCESS, LOAD_DATA, MERGE, DONE.
- IDLE -> ACCESS on accept when the request is legal and aligned; otherwise IDLE -> DONE with the error flag set. Memory is never touched on an error.
- ACCESS: drives o_mem_addr.
  - SW: we=1, write_data=wdata -> DONE.
  - Load, SB or SH: we=0 -> LOAD_DATA (load) or MERGE (store).
- LOAD_DATA: o_resp_valid=1.
  - rdata = lane of i_mem_read_data selected by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, LW passes through.
  - Next state IDLE.
- MERGE: we=1, same address.
  - write_data = i_mem_read_data with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Next state DONE.
- DONE: o_resp_valid=1, rdata=0, error as latched -> IDLE.
- Latency (accept edge = cycle 0): misaligned/illegal resp in cycle 1; SW resp in cycle 2; load resp in cycle 2; SB/SH resp in cycle 3.
- Throughput: next accept is possible in the response cycle's following edge (ready returns in IDLE).
- o_mem_write_enable is asserted only in ACCESS(SW) and MERGE, for exactly one cycle per store.
- Reset mid-operation: the state returns to IDLE at the reset edge and the in-flight request is dropped without a response. A sub-word store aborted before MERGE leaves memory unchanged.
- i_req_valid while not ready: ignored, no side effects.

Decomposition:
- Package dmem_lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum typedef lsu_state_t
  - helper function is_misaligned(funct3, addr[1:0])
- One combinational sub-module dmem_lsu_align: load lane extract/extend and store lane merge, shared by LOAD_DATA and MERGE.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF -> cycle 1 o_mem_addr=4, we=1, write_data=0xDEADBEEF; cycle 2 resp_valid, error=0; later LW 0x10 returns 0xDEADBEEF in cycle 2.
- Memory word 4 = 0x8081_7F80: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF8081... wait, 0x12 upper half = 0x8081 -> 0xFFFF8081; LHU 0x10 -> 0x00007F80.
- Word 4 = 0x11223344, SB 0x11 data 0xAA -> read cycle 1, MERGE write 0x1122AA44 cycle 2, resp cycle 3; SH 0x12 data 0xBEEF -> 0xBEEFAA44.
- LW 0x13, SH 0x11, funct3 011 load -> resp_valid cycle 1, error=1, rdata=0, we never asserted, memory unchanged.
- Assert i_rst during MERGE-bound SB (cycle 1) -> state IDLE next cycle, ready=1, no resp_valid, no write; word retains its old value.
- Back-to-back valid held high with 3 loads -> each accepted only when ready; responses in order, one per request.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types and decode helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_LOAD_DATA,
        S_MERGE,
        S_DONE
    } lsu_state_t;

    function automatic logic is_misaligned(
        input logic [2:0] funct3,
        input logic [1:0] a
    );
        logic r;
        r = 1'b0;
        case (funct3[1:0])
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(
        input logic       write,
        input logic [2:0] funct3
    );
        logic r;
        if (write)
            r = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            r = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    always_comb begin
        b          = rword[{lane, 3'b000} +: 8];
        h          = lane[1] ? rword[31:16] : rword[15:0];
        sx         = ~funct3[2];
        load_data  = rword;
        merge_data = rword;
        case (funct3[1:0])
            2'b00: begin
                load_data = {{24{sx & b[7]}}, b};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                load_data = {{16{sx & h[15]}}, h};
                if (lane[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory with one write enable.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_write_enable,
    input  logic [31:0] i_mem_read_data
);

    lsu_state_t            state;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  req_bad;
    logic                  req_sw;
    logic                  unused_addr;

    assign unused_addr = ^i_req_addr[31:ADDR_WIDTH+2];

    assign req_bad = is_illegal(i_req_write, i_req_funct3)
                   | is_misaligned(i_req_funct3, i_req_addr[1:0]);
    assign req_sw  = i_req_write && (i_req_funct3 == F3_W);

    dmem_lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .rword      (i_mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= S_IDLE;
            o_req_ready        <= 1'b1;
            o_resp_valid       <= 1'b0;
            o_resp_error       <= 1'b0;
            o_mem_write_enable <= 1'b0;
            addr_q             <= '0;
            funct3_q           <= '0;
            write_q            <= 1'b0;
            wdata_q            <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        funct3_q    <= i_req_funct3;
                        write_q     <= i_req_write;
                        wdata_q     <= i_req_wdata;
                        o_req_ready <= 1'b0;
                        if (req_bad) begin
                            state        <= S_DONE;
                            o_resp_valid <= 1'b1;
                            o_resp_error <= 1'b1;
                        end else begin
                            state              <= S_ACCESS;
                            addr_q             <= i_req_addr[ADDR_WIDTH+1:0];
                            o_mem_write_enable <= req_sw;
                        end
                    end
                end
                S_ACCESS: begin
                    o_mem_write_enable <= 1'b0;
                    if (write_q && funct3_q == F3_W) begin
                        state        <= S_DONE;
                        o_resp_valid <= 1'b1;
                    end else if (write_q) begin
                        // sub-word store: read cycle done, write merged word next
                        state              <= S_MERGE;
                        o_mem_write_enable <= 1'b1;
                    end else begin
                        state        <= S_LOAD_DATA;
                        o_resp_valid <= 1'b1;
                    end
                end
                S_MERGE: begin
                    state              <= S_DONE;
                    o_mem_write_enable <= 1'b0;
                    o_resp_valid       <= 1'b1;
                end
                S_LOAD_DATA, S_DONE: begin
                    state        <= S_IDLE;
                    o_resp_valid <= 1'b0;
                    o_resp_error <= 1'b0;
                    o_req_ready  <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_mem_addr = {{(32-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};

    // read data arrives combinationally in LOAD_DATA/MERGE
    assign o_resp_rdata = (state == S_LOAD_DATA) ? load_data : '0;

    always_comb begin
        o_mem_write_data = '0;
        if (state == S_MERGE)
            o_mem_write_data = merge_data;
        else if (o_mem_write_enable)
            o_mem_write_data = wdata_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a word memory model.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_error;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_write_data;
    logic        o_mem_write_enable;
    logic [31:0] i_mem_read_data;

    logic [31:0] mem [0:2047];
    int          wcount = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    dmem_lsu #(.ADDR_WIDTH(11)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_write        (i_req_write),
        .i_req_funct3       (i_req_funct3),
        .i_req_addr         (i_req_addr),
        .i_req_wdata        (i_req_wdata),
        .o_resp_valid       (o_resp_valid),
        .o_resp_rdata       (o_resp_rdata),
        .o_resp_error       (o_resp_error),
        .o_mem_addr         (o_mem_addr),
        .o_mem_write_data   (o_mem_write_data),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_read_data    (i_mem_read_data)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        i_mem_read_data <= mem[o_mem_addr[10:0]];
        if (o_mem_write_enable) begin
            mem[o_mem_addr[10:0]] <= o_mem_write_data;
            wcount <= wcount + 1;
        end
    end

    // Returns #1 after the accept edge (cycle 1).
    task automatic issue(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        i_req_write  = w;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = d;
        i_req_valid  = 1'b1;
        while (!o_req_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        n_cmp++;
        if (!o_req_ready) begin
            n_err++;
            $display("FAIL issue_ready: ready=%b required 1", o_req_ready);
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic err);
        issue(w, f3, a, d);
        lat = 1;
        while (!o_resp_valid && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        rd  = o_resp_rdata;
        err = o_resp_error;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp += 7;
        if (o_req_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_ready: got %b want 1", o_req_ready); end
        if (o_resp_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_valid: got %b want 0", o_resp_valid); end
        if (o_resp_error !== 1'b0) begin n_err++;
            $display("FAIL rst_error: got %b want 0", o_resp_error); end
        if (o_resp_rdata !== 32'h0) begin n_err++;
            $display("FAIL rst_rdata: got %h want 0", o_resp_rdata); end
        if (o_mem_addr !== 32'h0) begin n_err++;
            $display("FAIL rst_maddr: got %h want 0", o_mem_addr); end
        if (o_mem_write_data !== 32'h0) begin n_err++;
            $display("FAIL rst_mwdata: got %h want 0", o_mem_write_data); end
        if (o_mem_write_enable !== 1'b0) begin n_err++;
            $display("FAIL rst_mwe: got %b want 0", o_mem_write_enable); end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_sw_lw;
        int lat; logic [31:0] rd; logic err;
        issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        n_cmp += 5;
        if (o_mem_addr !== 32'd4) begin n_err++;
            $display("FAIL sw_addr: got %h want 4", o_mem_addr); end
        if (o_mem_write_enable !== 1'b1) begin n_err++;
            $display("FAIL sw_we: got %b want 1", o_mem_write_enable); end
        if (o_mem_write_data !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL sw_wdata: got %h want deadbeef", o_mem_write_data); end
        if (o_resp_valid !== 1'b0) begin n_err++;
            $display("FAIL sw_early: got %b want 0", o_resp_valid); end
        if (o_req_ready !== 1'b0) begin n_err++;
            $display("FAIL sw_busy: got %b want 0", o_req_ready); end
        @(posedge i_clk); #1;
        n_cmp += 4;
        if (o_resp_valid !== 1'b1) begin n_err++;
            $display("FAIL sw_resp: got %b want 1", o_resp_valid); end
        if (o_resp_error !== 1'b0) begin n_err++;
            $display("FAIL sw_err: got %b want 0", o_resp_error); end
        if (o_resp_rdata !== 32'h0) begin n_err++;
            $display("FAIL sw_rdata: got %h want 0", o_resp_rdata); end
        if (o_mem_write_enable !== 1'b0) begin n_err++;
            $display("FAIL sw_we_off: got %b want 0", o_mem_write_enable); end
        xact(1'b0, F3_W, 32'h10, 32'h0, lat, rd, err);
        n_cmp += 3;
        if (lat != 2) begin n_err++;
            $display("FAIL lw_lat: got %0d want 2", lat); end
        if (rd !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL lw_data: got %h want deadbeef", rd); end
        if (err !== 1'b0) begin n_err++;
            $display("FAIL lw_err: got %b want 0", err); end
    endtask

    task automatic test_load_ext;
        int lat; logic [31:0] rd; logic err;
        logic [2:0]  f3s [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU};
        logic [31:0] ads [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081,
                                 32'h00007F80, 32'hFFFFFF80, 32'h0000007F};
        xact(1'b1, F3_W, 32'h10, 32'h80817F80, lat, rd, err);
        for (int i = 0; i < 6; i++) begin
            xact(1'b0, f3s[i], ads[i], 32'h0, lat, rd, err);
            n_cmp += 2;
            if (rd !== exp[i] || err !== 1'b0) begin n_err++;
                $display("FAIL ld_ext%0d: got %h/%b want %h/0",
                         i, rd, err, exp[i]); end
            if (lat != 2) begin n_err++;
                $display("FAIL ld_lat%0d: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_subword_store;
        int lat; logic [31:0] rd; logic err; int w0;
        xact(1'b1, F3_W, 32'h10, 32'h11223344, lat, rd, err);
        w0 = wcount;
        issue(1'b1, F3_B, 32'h11, 32'h000000AA);
        n_cmp += 2;
        if (o_mem_write_enable !== 1'b0 || o_mem_addr !== 32'd4) begin n_err++;
            $display("FAIL sb_read: we=%b addr=%h want 0/4",
                     o_mem_write_enable, o_mem_addr); end
        if (o_resp_valid !== 1'b0) begin n_err++;
            $display("FAIL sb_c1_valid: got %b want 0", o_resp_valid); end
        @(posedge i_clk); #1;
        n_cmp += 3;
        if (o_mem_write_enable !== 1'b1) begin n_err++;
            $display("FAIL sb_merge_we: got %b want 1", o_mem_write_enable); end
        if (o_mem_write_data !== 32'h1122AA44) begin n_err++;
            $display("FAIL sb_merge: got %h want 1122aa44", o_mem_write_data); end
        if (o_resp_valid !== 1'b0) begin n_err++;
            $display("FAIL sb_c2_valid: got %b want 0", o_resp_valid); end
        @(posedge i_clk); #1;
        n_cmp += 2;
        if (o_resp_valid !== 1'b1 || o_resp_error !== 1'b0) begin n_err++;
            $display("FAIL sb_resp: valid=%b err=%b want 1/0",
                     o_resp_valid, o_resp_error); end
        if (o_mem_write_enable !== 1'b0) begin n_err++;
            $display("FAIL sb_we_off: got %b want 0", o_mem_write_enable); end
        xact(1'b1, F3_H, 32'h12, 32'h0000BEEF, lat, rd, err);
        n_cmp += 2;
        if (lat != 3 || err !== 1'b0) begin n_err++;
            $display("FAIL sh_lat: got %0d/%b want 3/0", lat, err); end
        if (wcount - w0 != 2) begin n_err++;
            $display("FAIL sub_wcount: got %0d want 2", wcount - w0); end
        xact(1'b0, F3_W, 32'h10, 32'h0, lat, rd, err);
        n_cmp++;
        if (rd !== 32'hBEEFAA44) begin n_err++;
            $display("FAIL sh_result: got %h want beefaa44", rd); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic err; int w0;
        logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{F3_W, F3_H, 3'b011, 3'b100};
        logic [31:0] ads [4] = '{32'h13, 32'h11, 32'h10, 32'h10};
        w0 = wcount;
        for (int i = 0; i < 4; i++) begin
            xact(ws[i], f3s[i], ads[i], 32'hFFFFFFFF, lat, rd, err);
            n_cmp++;
            if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin n_err++;
                $display("FAIL err%0d: lat=%0d err=%b rd=%h want 1/1/0",
                         i, lat, err, rd); end
        end
        n_cmp++;
        if (wcount != w0) begin n_err++;
            $display("FAIL err_wcount: got %0d want %0d", wcount, w0); end
        xact(1'b0, F3_W, 32'h10, 32'h0, lat, rd, err);
        n_cmp++;
        if (rd !== 32'hBEEFAA44) begin n_err++;
            $display("FAIL err_mem: got %h want beefaa44", rd); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic err; int w0; int nv = 0;
        w0 = wcount;
        issue(1'b1, F3_B, 32'h10, 32'h00000055);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        n_cmp += 2;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin n_err++;
            $display("FAIL rmid_state: ready=%b valid=%b want 1/0",
                     o_req_ready, o_resp_valid); end
        if (o_mem_write_enable !== 1'b0) begin n_err++;
            $display("FAIL rmid_we: got %b want 0", o_mem_write_enable); end
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            if (o_resp_valid) nv++;
        end
        n_cmp += 2;
        if (nv != 0) begin n_err++;
            $display("FAIL rmid_resp: got %0d want 0", nv); end
        if (wcount != w0) begin n_err++;
            $display("FAIL rmid_write: got %0d want %0d", wcount, w0); end
        xact(1'b0, F3_W, 32'h10, 32'h0, lat, rd, err);
        n_cmp++;
        if (rd !== 32'hBEEFAA44) begin n_err++;
            $display("FAIL rmid_mem: got %h want beefaa44", rd); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s [3] = '{F3_W, F3_BU, F3_H};
        logic [31:0] ads [3] = '{32'h10, 32'h13, 32'h10};
        logic [31:0] exp [3] = '{32'hBEEFAA44, 32'h000000BE, 32'hFFFFAA44};
        logic [31:0] got [3];
        int nacc = 0; int nresp = 0; logic rb;
        i_req_write  = 1'b0;
        i_req_funct3 = f3s[0];
        i_req_addr   = ads[0];
        i_req_valid  = 1'b1;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            rb = o_req_ready;
            @(posedge i_clk); #1;
            if (rb && i_req_valid) begin
                nacc++;
                if (nacc < 3) begin
                    i_req_funct3 = f3s[nacc];
                    i_req_addr   = ads[nacc];
                end else begin
                    i_req_valid = 1'b0;
                end
            end
            if (o_resp_valid) begin
                if (nresp < 3) got[nresp] = o_resp_rdata;
                nresp++;
            end
        end
        i_req_valid = 1'b0;
        n_cmp += 2;
        if (nacc != 3) begin n_err++;
            $display("FAIL b2b_acc: got %0d want 3", nacc); end
        if (nresp != 3) begin n_err++;
            $display("FAIL b2b_resp: got %0d want 3", nresp); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin n_err++;
                $display("FAIL b2b_data%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_subword_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
